// File: rtl/controller_pkg.sv
// Shared encodings for the ARM-subset control unit: opcode classes, data-processing
// commands, ALU / result-mux selects, condition codes and NZCV bit positions.
package controller_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_EOR = 4'b0001,
    CMD_SUB = 4'b0010,
    CMD_RSB = 4'b0011,
    CMD_ADD = 4'b0100,
    CMD_ADC = 4'b0101,
    CMD_SBC = 4'b0110,
    CMD_RSC = 4'b0111,
    CMD_TST = 4'b1000,
    CMD_TEQ = 4'b1001,
    CMD_CMP = 4'b1010,
    CMD_CMN = 4'b1011,
    CMD_ORR = 4'b1100,
    CMD_MOV = 4'b1101,
    CMD_BIC = 4'b1110,
    CMD_MVN = 4'b1111
  } dp_cmd_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_ADC = 3'b100,
    ALU_SBC = 3'b101,
    ALU_EOR = 3'b110
  } alu_ctl_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_SRCB = 2'b01,
    RES_MUL  = 2'b10
  } result_src_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] MUL_ID = 4'b1001;
  localparam logic [3:0] PC_REG = 4'b1111;

  // Commands whose C and V results come from the adder.
  function automatic logic is_arith(input dp_cmd_e cmd);
    return cmd inside {CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC, CMD_SBC,
                       CMD_RSC, CMD_CMP, CMD_CMN};
  endfunction

endpackage

// File: rtl/controller_cond_logic.sv
// NZCV flags register and condition evaluation; flag writes are gated by the
// instruction's own condition, which always sees the pre-edge flags.
module cond_logic
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_wr_nz,
  input  logic       flag_wr_cv,
  output logic       cond_ex,
  output logic [3:0] flags
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       n, z, c, v;

  assign n     = flags_q[FLAG_N];
  assign z     = flags_q[FLAG_Z];
  assign c     = flags_q[FLAG_C];
  assign v     = flags_q[FLAG_V];
  assign flags = flags_q;

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;  // AL and the unconditional 1111 space
    endcase
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; that is what keeps a latch from being inferred.
    flags_d = flags_q;
    if (cond_ex && flag_wr_nz) begin
      flags_d[FLAG_N] = alu_flags[FLAG_N];
      flags_d[FLAG_Z] = alu_flags[FLAG_Z];
    end
    if (cond_ex && flag_wr_cv) begin
      flags_d[FLAG_C] = alu_flags[FLAG_C];
      flags_d[FLAG_V] = alu_flags[FLAG_V];
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/controller.sv
// Single-cycle ARM-subset control unit: decodes op/funct/rd/instr[7:4] into datapath
// controls and gates architectural writes with the condition check.
module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [3:0] rd,
  input  logic [3:0] instr74,
  input  logic [5:0] funct,
  output logic       pc_src,
  output logic       reg_write3,
  output logic       reg_write1,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       carry,
  output logic       swap,
  output logic       inv,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic       reg_src,
  output logic [2:0] alu_ctl,
  output logic [3:0] mul_ctl
);

  dp_cmd_e     cmd;
  alu_ctl_e    alu_op;
  result_src_e res_sel;
  logic        is_mul;
  logic        is_branch;
  logic        rw3_pre, rw1_pre, mw_pre;
  logic        use_carry;
  logic        flag_wr_nz, flag_wr_cv;
  logic        cond_ex;
  logic [3:0]  flags;

  assign cmd       = dp_cmd_e'(funct[4:1]);
  assign is_mul    = (op == OP_DP) && (funct[5:4] == 2'b00) && (instr74 == MUL_ID);
  assign is_branch = (op == OP_BR);

  always_comb begin
    rw3_pre    = 1'b0;
    rw1_pre    = 1'b0;
    mw_pre     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    swap       = 1'b0;
    inv        = 1'b0;
    use_carry  = 1'b0;
    reg_src    = 1'b0;
    alu_op     = ALU_ADD;
    res_sel    = RES_ALU;
    mul_ctl    = 4'b0000;
    flag_wr_nz = 1'b0;
    flag_wr_cv = 1'b0;

    case (op)
      OP_DP: begin
        if (is_mul) begin
          mul_ctl    = {1'b1, funct[3:1]};
          res_sel    = RES_MUL;
          rw3_pre    = 1'b1;
          rw1_pre    = funct[3];
          flag_wr_nz = funct[0];
        end else begin
          alu_src    = funct[5];
          flag_wr_nz = funct[0];
          flag_wr_cv = funct[0] & is_arith(cmd);
          // Compare/test commands only set flags.
          rw3_pre    = !(cmd inside {CMD_TST, CMD_TEQ, CMD_CMP, CMD_CMN});
          swap       = cmd inside {CMD_RSB, CMD_RSC};
          inv        = cmd inside {CMD_BIC, CMD_MVN};
          use_carry  = cmd inside {CMD_ADC, CMD_SBC, CMD_RSC};
          if (cmd inside {CMD_MOV, CMD_MVN}) res_sel = RES_SRCB;
          case (cmd)
            CMD_ADD, CMD_CMN:          alu_op = ALU_ADD;
            CMD_SUB, CMD_CMP, CMD_RSB: alu_op = ALU_SUB;
            CMD_AND, CMD_TST, CMD_BIC: alu_op = ALU_AND;
            CMD_ORR:                   alu_op = ALU_ORR;
            CMD_ADC:                   alu_op = ALU_ADC;
            CMD_SBC, CMD_RSC:          alu_op = ALU_SBC;
            CMD_EOR, CMD_TEQ:          alu_op = ALU_EOR;
            default:                   alu_op = ALU_ADD;
          endcase
        end
      end
      OP_MEM: begin
        // funct = {~I, P, U, B, W, L}
        alu_src    = 1'b1;
        alu_op     = funct[3] ? ALU_ADD : ALU_SUB;
        mw_pre     = ~funct[0];
        mem_to_reg = funct[0];
        rw3_pre    = funct[0];
        rw1_pre    = funct[1] | ~funct[4];
      end
      OP_BR: begin
        alu_src = 1'b1;
        reg_src = 1'b1;
      end
      default: ;
    endcase
  end

  cond_logic cond_logic (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .alu_flags  (alu_flags),
    .flag_wr_nz (flag_wr_nz),
    .flag_wr_cv (flag_wr_cv),
    .cond_ex    (cond_ex),
    .flags      (flags)
  );

  assign imm_src    = op;
  assign alu_ctl    = alu_op;
  assign result_src = res_sel;
  assign carry      = use_carry & flags[FLAG_C];

  assign pc_src     = cond_ex & (is_branch | ((rd == PC_REG) & rw3_pre));
  assign reg_write3 = cond_ex & rw3_pre;
  assign reg_write1 = cond_ex & rw1_pre;
  assign mem_write  = cond_ex & mw_pre;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed scenarios plus randomized
// instructions checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [3:0] cond, alu_flags, rd, instr74;
  logic [5:0] funct;
  logic       pc_src, reg_write3, reg_write1, mem_write, mem_to_reg, alu_src;
  logic       carry, swap, inv, reg_src;
  logic [1:0] imm_src, result_src;
  logic [2:0] alu_ctl;
  logic [3:0] mul_ctl;

  int n_checks = 0;
  int n_bad    = 0;

  // ALU operation per data-processing command, ordered AND..MVN.
  logic [2:0] alu_tab [16] = '{3'd2, 3'd6, 3'd1, 3'd1, 3'd0, 3'd4, 3'd5, 3'd5,
                               3'd2, 3'd6, 3'd1, 3'd0, 3'd3, 3'd0, 3'd2, 3'd0};

  logic [20:0] got;
  assign got = {pc_src, reg_write3, reg_write1, mem_write, mem_to_reg, alu_src,
                carry, swap, inv, imm_src, result_src, reg_src, alu_ctl, mul_ctl};

  controller dut (
    .clk(clk), .reset(reset), .op(op), .cond(cond), .alu_flags(alu_flags),
    .rd(rd), .instr74(instr74), .funct(funct), .pc_src(pc_src),
    .reg_write3(reg_write3), .reg_write1(reg_write1), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .carry(carry), .swap(swap),
    .inv(inv), .imm_src(imm_src), .result_src(result_src), .reg_src(reg_src),
    .alu_ctl(alu_ctl), .mul_ctl(mul_ctl)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] o, input logic [3:0] c, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] i74, input logic [3:0] af);
    op = o; cond = c; funct = f; rd = r; instr74 = i74; alu_flags = af;
  endtask

  // Instruction-level model: expected outputs for one instruction given the stored flags.
  function automatic logic [20:0] model(input logic [1:0] o, input logic [3:0] c,
      input logic [5:0] f, input logic [3:0] r, input logic [3:0] i74,
      input logic [3:0] fl, output logic wnz, output logic wcv);
    logic n, z, cf, v, ce, br, mul;
    logic [15:0] pass;
    logic e_pc, rw3, rw1, mw, m2r, asrc, ecar, esw, einv, rsrc;
    logic [1:0] rs;
    logic [2:0] alu;
    logic [3:0] mc;
    int cmd;
    n = fl[3]; z = fl[2]; cf = fl[1]; v = fl[0];
    pass = {1'b1, 1'b1, z | (n != v), !z && (n == v), n != v, n == v, !cf || z,
            cf && !z, !v, v, !n, n, !cf, cf, !z, z};
    ce = pass[c];
    {rw3, rw1, mw, m2r, asrc, ecar, esw, einv, rsrc, br} = '0;
    rs = 2'd0; alu = 3'd0; mc = 4'd0; wnz = 1'b0; wcv = 1'b0;
    mul = (o == 2'd0) && (f[5:4] == 2'd0) && (i74 == 4'd9);
    cmd = int'(f[4:1]);
    if (mul) begin
      mc = {1'b1, f[3:1]}; rs = 2'd2; rw3 = 1'b1; rw1 = f[3]; wnz = f[0];
    end else if (o == 2'd0) begin
      asrc = f[5];
      rw3  = !(cmd >= 8 && cmd <= 11);
      alu  = alu_tab[cmd];
      esw  = (cmd == 3 || cmd == 7);
      einv = (cmd == 14 || cmd == 15);
      ecar = (cmd >= 5 && cmd <= 7) && cf;
      rs   = (cmd == 13 || cmd == 15) ? 2'd1 : 2'd0;
      wnz  = f[0];
      wcv  = f[0] && ((cmd >= 2 && cmd <= 7) || cmd == 10 || cmd == 11);
    end else if (o == 2'd1) begin
      asrc = 1'b1; alu = f[3] ? 3'd0 : 3'd1;
      mw = !f[0]; m2r = f[0]; rw3 = f[0]; rw1 = f[1] || !f[4];
    end else if (o == 2'd2) begin
      asrc = 1'b1; rsrc = 1'b1; br = 1'b1;
    end
    e_pc = ce && (br || (r == 4'd15 && rw3));
    wnz = wnz && ce; wcv = wcv && ce;
    return {e_pc, rw3 && ce, rw1 && ce, mw && ce, m2r, asrc, ecar, esw, einv,
            o, rs, rsrc, alu, mc};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    drive(2'b00, 4'b0000, 6'b001010, 4'd0, 4'd0, 4'b1111);
    #1;
    n_checks++;
    if (carry !== 1'b0) begin n_bad++; $display("FAIL reset_carry got=%b exp=0", carry); end
    n_checks++;
    if (reg_write3 !== 1'b0) begin n_bad++; $display("FAIL reset_eq_gate got=%b exp=0", reg_write3); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_branch;
    @(negedge clk); drive(2'b10, 4'b1110, 6'b000000, 4'd0, 4'd0, 4'd0); #1;
    n_checks++;
    if ({pc_src, reg_src, imm_src, reg_write3} !== 5'b11100) begin
      n_bad++; $display("FAIL branch got=%b exp=11100", {pc_src, reg_src, imm_src, reg_write3});
    end
    @(negedge clk); drive(2'b00, 4'b1110, 6'b000000, 4'd0, 4'd0, 4'd0); #1;
    n_checks++;
    if (pc_src !== 1'b0) begin n_bad++; $display("FAIL and_rd0_pc got=%b exp=0", pc_src); end
  endtask

  task automatic test_memory;
    @(negedge clk); drive(2'b01, 4'b1110, 6'b010000, 4'd1, 4'd0, 4'd0); #1;
    n_checks++;
    if ({mem_write, reg_write3, alu_ctl} !== 5'b10001) begin
      n_bad++; $display("FAIL store got=%b exp=10001", {mem_write, reg_write3, alu_ctl});
    end
    @(negedge clk); drive(2'b01, 4'b1110, 6'b010001, 4'd1, 4'd0, 4'd0); #1;
    n_checks++;
    if ({reg_write3, mem_to_reg, mem_write} !== 3'b110) begin
      n_bad++; $display("FAIL load got=%b exp=110", {reg_write3, mem_to_reg, mem_write});
    end
    @(negedge clk); drive(2'b01, 4'b1110, 6'b111000, 4'd1, 4'd0, 4'd0); #1;
    n_checks++;
    if ({reg_write1, alu_ctl} !== 4'b0000) begin
      n_bad++; $display("FAIL no_wb got=%b exp=0000", {reg_write1, alu_ctl});
    end
    @(negedge clk); drive(2'b01, 4'b1110, 6'b111010, 4'd1, 4'd0, 4'd0); #1;
    n_checks++;
    if (reg_write1 !== 1'b1) begin n_bad++; $display("FAIL wb got=%b exp=1", reg_write1); end
  endtask

  task automatic test_alu_decode;
    logic [5:0] fv [5] = '{6'b001000, 6'b000100, 6'b000000, 6'b011000, 6'b001010};
    logic [2:0] ev [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(2'b00, 4'b1110, fv[i], 4'd2, 4'd0, 4'd0); #1;
      n_checks++;
      if (alu_ctl !== ev[i]) begin
        n_bad++; $display("FAIL alu_ctl[%0d] got=%b exp=%b", i, alu_ctl, ev[i]);
      end
    end
    @(negedge clk); drive(2'b00, 4'b1110, 6'b011010, 4'd2, 4'd0, 4'd0); #1;
    n_checks++;
    if (result_src !== 2'b01) begin n_bad++; $display("FAIL mov_src got=%b exp=01", result_src); end
  endtask

  task automatic test_flags_carry;
    @(negedge clk); drive(2'b00, 4'b1110, 6'b001001, 4'd2, 4'd0, 4'b0000); #1;
    n_checks++;
    if ({swap, inv, carry} !== 3'b000) begin
      n_bad++; $display("FAIL adds got=%b exp=000", {swap, inv, carry});
    end
    @(negedge clk); drive(2'b00, 4'b1110, 6'b001011, 4'd2, 4'd0, 4'b0010); #1;
    n_checks++;
    if (carry !== 1'b0) begin n_bad++; $display("FAIL adc_pre got=%b exp=0", carry); end
    @(posedge clk); #1;
    n_checks++;
    if (carry !== 1'b1) begin n_bad++; $display("FAIL adc_post got=%b exp=1", carry); end
    @(negedge clk); drive(2'b00, 4'b1110, 6'b000111, 4'd2, 4'd0, 4'b0010); #1;
    n_checks++;
    if (swap !== 1'b1) begin n_bad++; $display("FAIL rsb_swap got=%b exp=1", swap); end
    @(negedge clk); drive(2'b00, 4'b1110, 6'b011101, 4'd2, 4'd0, 4'b0010); #1;
    n_checks++;
    if (inv !== 1'b1) begin n_bad++; $display("FAIL bic_inv got=%b exp=1", inv); end
  endtask

  task automatic test_multiply;
    @(negedge clk); drive(2'b00, 4'b1110, 6'b001000, 4'd3, 4'b1001, 4'd0); #1;
    n_checks++;
    if ({mul_ctl, result_src, reg_write3, reg_write1} !== 8'b11001011) begin
      n_bad++; $display("FAIL mul got=%b exp=11001011", {mul_ctl, result_src, reg_write3, reg_write1});
    end
    @(negedge clk); drive(2'b00, 4'b1110, 6'b001000, 4'd3, 4'b0000, 4'd0); #1;
    n_checks++;
    if ({mul_ctl, result_src} !== 6'b000000) begin
      n_bad++; $display("FAIL not_mul got=%b exp=000000", {mul_ctl, result_src});
    end
  endtask

  task automatic test_cond_gate;
    @(negedge clk); reset = 1'b1; #1; reset = 1'b0;
    drive(2'b00, 4'b0000, 6'b001001, 4'd15, 4'd0, 4'b0100); #1;
    n_checks++;
    if ({pc_src, reg_write3} !== 2'b00) begin
      n_bad++; $display("FAIL eq_dp got=%b exp=00", {pc_src, reg_write3});
    end
    @(posedge clk); #1;
    n_checks++;
    if (reg_write3 !== 1'b0) begin n_bad++; $display("FAIL eq_flag_gate got=%b exp=0", reg_write3); end
    @(negedge clk); drive(2'b01, 4'b0000, 6'b010010, 4'd1, 4'd0, 4'd0); #1;
    n_checks++;
    if ({mem_write, reg_write1} !== 2'b00) begin
      n_bad++; $display("FAIL eq_mem got=%b exp=00", {mem_write, reg_write1});
    end
    @(negedge clk); drive(2'b10, 4'b0000, 6'b000000, 4'd0, 4'd0, 4'd0); #1;
    n_checks++;
    if (pc_src !== 1'b0) begin n_bad++; $display("FAIL eq_branch got=%b exp=0", pc_src); end
    @(negedge clk); drive(2'b00, 4'b1111, 6'b001000, 4'd15, 4'd0, 4'd0); #1;
    n_checks++;
    if ({pc_src, reg_write3} !== 2'b11) begin
      n_bad++; $display("FAIL nv_always got=%b exp=11", {pc_src, reg_write3});
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); drive(2'b00, 4'b1110, 6'b001011, 4'd2, 4'd0, 4'b0110);
    @(posedge clk); #1;
    @(negedge clk); drive(2'b00, 4'b0000, 6'b001010, 4'd2, 4'd0, 4'b0000); #1;
    n_checks++;
    if ({reg_write3, carry} !== 2'b11) begin
      n_bad++; $display("FAIL pre_reset got=%b exp=11", {reg_write3, carry});
    end
    #1 reset = 1'b1; #1;
    n_checks++;
    if ({reg_write3, carry} !== 2'b00) begin
      n_bad++; $display("FAIL mid_reset got=%b exp=00", {reg_write3, carry});
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_random;
    logic [3:0] fl = 4'b0000;
    logic [20:0] exp_v;
    logic wnz, wcv;
    @(negedge clk); reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 3)), 4'($urandom), 6'($urandom), 4'($urandom),
            ($urandom_range(0, 1) == 1) ? 4'b1001 : 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) funct[5:4] = 2'b00;
      if ($urandom_range(0, 3) == 0) rd = 4'd15;
      #1;
      exp_v = model(op, cond, funct, rd, instr74, fl, wnz, wcv);
      n_checks++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL random[%0d] op=%b cond=%b funct=%b rd=%0d i74=%b got=%b exp=%b",
                 i, op, cond, funct, rd, instr74, got, exp_v);
      end
      @(posedge clk);
      if (wnz) fl[3:2] = alu_flags[3:2];
      if (wcv) fl[1:0] = alu_flags[1:0];
    end
  endtask

  initial begin
    test_reset;
    test_branch;
    test_memory;
    test_alu_decode;
    test_flags_carry;
    test_multiply;
    test_cond_gate;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
